// File: rtl/pushbutton_processor.sv
// Pushbutton front end for the scoreboard counter.
// Turns one raw, bouncy, asynchronous button into single-cycle commands:
// a short press gives count_up on release, and a press held for LONG_PRESS_MS
// cycles gives count_down while the button is still held. Everything runs
// from the 1 kHz clock, so one cycle is one millisecond.
//
// Ports:
//   clk_1khz     - 1 kHz system clock, rising edge
//   rst_i        - synchronous active-high reset
//   pushbutton_i - raw button level, 1 = pressed (asynchronous, bouncy)
//   count_up     - one-cycle pulse when a short press completes
//   count_down   - one-cycle pulse when a long press is recognised
module pushbutton_processor #(
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 2000,
  parameter int unsigned CNT_W         = 11
) (
  input  logic clk_1khz,
  input  logic rst_i,
  input  logic pushbutton_i,
  output logic count_up,
  output logic count_down
);

  localparam int unsigned      DbW      = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] HoldLong = CNT_W'(LONG_PRESS_MS);
  localparam logic [CNT_W-1:0] HoldMax  = '1;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLongDone
  } state_e;

  logic [1:0]       sync_q;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic             db_level_q, db_level_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             up_d, down_d;

  // Debouncer: the level flips on the DEBOUNCE_MS-th consecutive differing cycle.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sync_q[1] != db_level_q) begin
      if (db_cnt_q == DbLast) begin
        db_level_d = ~db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // Press classifier. The FSM state tracks the debounced level, so seeing
  // level 1 in StIdle is the rising edge and level 0 in StPressed the falling
  // edge. The threshold test comes first so a release on the very cycle the
  // threshold is reached still counts as a long press.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        hold_d = '0;
        if (db_level_q) begin
          state_d = StPressed;
          hold_d  = CNT_W'(1);
        end
      end
      StPressed: begin
        if (hold_q >= HoldLong) begin
          down_d  = 1'b1;
          state_d = StLongDone;
          hold_d  = '0;
        end else if (!db_level_q) begin
          up_d    = 1'b1;
          state_d = StIdle;
          hold_d  = '0;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      StLongDone: begin
        hold_d = '0;
        if (!db_level_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      sync_q     <= '0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      state_q    <= StIdle;
      hold_q     <= '0;
      count_up   <= 1'b0;
      count_down <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], pushbutton_i};
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      count_up   <= up_d;
      count_down <= down_d;
    end
  end

endmodule

// File: tb/tb_pushbutton_processor.sv
// Bench for pushbutton_processor: directed scenarios plus random presses.
// Inputs and outputs are logged per clock; afterwards a timeline model
// derives the debounced level and the expected pulses from the recorded input.
module tb_pushbutton_processor;

  localparam int DEB      = 20;
  localparam int LONGP    = 2000;
  localparam int MAXC     = 50000;
  localparam int SHORTLAT = 2 + DEB;          // raw release sample -> count_up
  localparam int LONGLAT  = 2 + DEB + LONGP;  // raw press sample -> count_down

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic pushbutton_i = 1'b0;
  logic count_up, count_down;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  bit raw_a[MAXC];
  bit rst_a[MAXC];
  bit up_a[MAXC];
  bit dn_a[MAXC];
  bit lvl_m[MAXC];
  bit exp_up[MAXC];
  bit exp_dn[MAXC];

  pushbutton_processor #(
    .DEBOUNCE_MS  (DEB),
    .LONG_PRESS_MS(LONGP),
    .CNT_W        (11)
  ) dut (
    .clk_1khz    (clk),
    .rst_i       (rst_i),
    .pushbutton_i(pushbutton_i),
    .count_up    (count_up),
    .count_down  (count_down)
  );

  always #5 clk = ~clk;

  // Log inputs at the edge and registered outputs just after it.
  always @(posedge clk) begin
    if (cyc < MAXC) begin
      raw_a[cyc] = pushbutton_i;
      rst_a[cyc] = rst_i;
    end
    #1;
    if (cyc < MAXC) begin
      up_a[cyc] = count_up;
      dn_a[cyc] = count_down;
    end
    cyc++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold the button at v for n cycles; first = log index of the first sample.
  task automatic drive(input bit v, input int n, output int first);
    first = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pushbutton_i = v;
      if (i == 0) first = cyc;
    end
  endtask

  function automatic bit synced(input int idx);
    if (idx < 2) return 1'b0;
    if (rst_a[idx-1] || rst_a[idx-2]) return 1'b0;
    return raw_a[idx-2];
  endfunction

  function automatic int count_in(input bit down, input int from, input int to);
    int n = 0;
    for (int c = from; c < to; c++) n += down ? int'(dn_a[c]) : int'(up_a[c]);
    return n;
  endfunction

  function automatic int first_after(input bit down, input int from, input int lim);
    for (int c = from; c < lim; c++) begin
      if (down ? dn_a[c] : up_a[c]) return c - from;
    end
    return -1;
  endfunction

  initial begin
    int d, t, w_bounce, w_short, w_long, w_b1, w_b2, w_rb, w_rst, w_end;
    int rel_short, press_long, total;

    // Power-on reset with the button released.
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    check_eq("reset_up", count_up, 0);
    check_eq("reset_dn", count_down, 0);
    @(negedge clk);
    rst_i = 1'b0;
    drive(1'b0, 30, d);

    // Reset in the middle of a held press: outputs stay low, press restarts.
    drive(1'b1, 100, w_rst);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst_i = 1'b1;
      pushbutton_i = 1'b1;
      @(posedge clk);
      #2;
      check_eq("rst_hold_up", count_up, 0);
      check_eq("rst_hold_dn", count_down, 0);
    end
    @(negedge clk);
    rst_i = 1'b0;
    drive(1'b1, 60, d);
    drive(1'b0, 80, d);

    // Bounce rejection.
    drive(1'b1, 1, w_bounce);
    drive(1'b0, 2, d);
    drive(1'b1, 2, d);
    drive(1'b0, 1, d);
    drive(1'b1, 1, d);
    drive(1'b0, 50, d);

    // Short press with leading bounces.
    drive(1'b1, 1, w_short);
    drive(1'b0, 2, d);
    drive(1'b1, 2, d);
    drive(1'b0, 1, d);
    drive(1'b1, 1, d);
    drive(1'b1, 30, d);
    drive(1'b0, 60, rel_short);

    // Long press.
    drive(1'b1, 2130, press_long);
    w_long = press_long;
    drive(1'b0, 60, d);

    // Boundary holds either side of the threshold.
    drive(1'b1, 1995, w_b1);
    drive(1'b0, 60, d);
    drive(1'b1, 2005, w_b2);
    drive(1'b0, 60, d);

    // Bouncy release after a 100 ms hold.
    drive(1'b1, 100, w_rb);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5, d);
      drive(1'b1, 5, d);
    end
    drive(1'b0, 60, w_end);

    // Random presses with random bounce.
    for (int p = 0; p < 12; p++) begin
      int nb, hold_len;
      nb = $urandom_range(0, 4);
      for (int b = 0; b < nb; b++) begin
        drive(1'b1, $urandom_range(1, DEB - 2), d);
        drive(1'b0, $urandom_range(1, DEB - 2), d);
      end
      hold_len = ($urandom_range(0, 3) == 0) ? $urandom_range(1900, 2200)
                                             : $urandom_range(5, 400);
      drive(1'b1, hold_len, d);
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        drive(1'b0, $urandom_range(1, DEB - 2), d);
        drive(1'b1, $urandom_range(1, DEB - 2), d);
      end
      drive(1'b0, $urandom_range(60, 120), d);
    end
    drive(1'b0, 40, d);
    @(posedge clk);
    #3;
    total = (cyc < MAXC) ? cyc : MAXC;

    // Timeline model: the debounced level takes the synchronised value once
    // that value has disagreed with it for DEB consecutive reset-free cycles.
    for (int c = 0; c < total; c++) begin
      bit prev, tog;
      prev = (c == 0) ? 1'b0 : lvl_m[c-1];
      if (rst_a[c]) begin
        lvl_m[c] = 1'b0;
      end else begin
        tog = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          if (c - k < 0) tog = 1'b0;
          else if (rst_a[c-k] || synced(c - k) == prev) tog = 1'b0;
        end
        lvl_m[c] = tog ? ~prev : prev;
      end
    end

    // Each debounced press of length D yields count_down LONGP+1 cycles after
    // the rise if D >= LONGP, else count_up one cycle after the fall; a reset
    // anywhere in between cancels it.
    for (int a = 0; a < total; a++) begin
      if (lvl_m[a] && (a == 0 || !lvl_m[a-1])) begin
        int f, e;
        bit kill;
        f = a + 1;
        while (f < total && lvl_m[f]) f++;
        e = (f - a >= LONGP) ? a + 1 + LONGP : f + 1;
        kill = 1'b0;
        for (int r = a + 1; r <= e && r < total; r++) if (rst_a[r]) kill = 1'b1;
        if (!kill && e < total) begin
          if (f - a >= LONGP) exp_dn[e] = 1'b1;
          else exp_up[e] = 1'b1;
        end
      end
    end

    for (int c = 0; c < total; c++) begin
      if (up_a[c] || exp_up[c]) check_eq($sformatf("count_up@%0d", c), up_a[c], exp_up[c]);
      if (dn_a[c] || exp_dn[c]) check_eq($sformatf("count_down@%0d", c), dn_a[c], exp_dn[c]);
      if (up_a[c] && dn_a[c]) check_eq($sformatf("both@%0d", c), 1, 0);
    end

    // Scenario-level expectations taken straight from the press rules.
    check_eq("rst_press_ups", count_in(1'b0, w_rst, w_bounce), 1);
    check_eq("rst_press_dns", count_in(1'b1, w_rst, w_bounce), 0);
    check_eq("bounce_ups", count_in(1'b0, w_bounce, w_short), 0);
    check_eq("bounce_dns", count_in(1'b1, w_bounce, w_short), 0);
    check_eq("short_ups", count_in(1'b0, w_short, w_long), 1);
    check_eq("short_dns", count_in(1'b1, w_short, w_long), 0);
    check_eq("short_latency", first_after(1'b0, rel_short, w_long), SHORTLAT);
    check_eq("long_dns", count_in(1'b1, w_long, w_b1), 1);
    check_eq("long_ups", count_in(1'b0, w_long, w_b1), 0);
    check_eq("long_latency", first_after(1'b1, press_long, w_b1), LONGLAT);
    check_eq("b1995_ups", count_in(1'b0, w_b1, w_b2), 1);
    check_eq("b1995_dns", count_in(1'b1, w_b1, w_b2), 0);
    check_eq("b2005_ups", count_in(1'b0, w_b2, w_rb), 0);
    check_eq("b2005_dns", count_in(1'b1, w_b2, w_rb), 1);
    check_eq("relbounce_ups", count_in(1'b0, w_rb, w_end + 60), 1);
    check_eq("relbounce_dns", count_in(1'b1, w_rb, w_end + 60), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
